snn_host_sequencer: RTL
=======================

// Module: snn_host_sequencer
// PURPOSE
//  Bus-master job sequencer for the SNN accelerator register slave. Streams one image into the
//  slave's pixel window, holds start_compute, polls status until done, reads the 10 result
//  registers, and reports per-class spike scores plus the argmax class.
//  Sits between the pixel source (DMA/camera FIFO) and the accelerator's host port.
// PARAMETERS
//  NUM_PIXELS     3072      pixels per image; must be a multiple of 4
//  NUM_CLASSES    10        result registers read back
//  PIX_BASE       32'h100   byte address of the first pixel word
//  POLL_GAP       16        idle cycles between status polls
//  TIMEOUT_POLLS  65535     polls before giving up
// PORTS
//  clk            in   1    single clock
//  rst            in   1    asynchronous, active-high reset
//  job_start      in   1    one-cycle request; ignored unless busy=0
//  pix_data       in   8    pixel byte
//  pix_valid      in   1    pix_data valid
//  pix_ready      out  1    byte accepted when pix_valid&pix_ready
//  bus_addr       out  32   to slave host_addr
//  bus_wdata      out  32   to slave host_data_in
//  bus_write_en   out  1    one-cycle write strobe
//  bus_read_en    out  1    one-cycle read strobe
//  bus_rdata      in   32   from slave host_data_out; valid 1 cycle after bus_read_en
//  start_compute  out  1    level; held high for the whole compute phase
//  busy           out  1    high from accepted job_start to result_valid/timeout
//  result_valid   out  1    one-cycle pulse; scores/class_id stable until next job_start
//  scores         out  80   {score[9],...,score[0]}, 8 bits each
//  class_id       out  4    argmax of scores
//  timeout_err    out  1    sticky until next accepted job_start
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, counters 0, score registers 0.
//  FSM: IDLE -> LOAD -> START -> POLL_GAP -> POLL_RD -> POLL_WT -> RES_RD -> RES_WT -> FINISH -> IDLE.
//  IDLE: pix_ready=0. job_start -> LOAD; clear timeout_err, byte/word counters.
//  LOAD: pix_ready=1 except in the cycle bus_write_en is high. Packs bytes little-endian
//   (first byte in [7:0]). On the 4th byte, next cycle: bus_write_en=1,
//   bus_addr=PIX_BASE+4*word_idx, bus_wdata=packed word. After word NUM_PIXELS/4-1 -> START.
//  START: start_compute<=1 (held through POLL_*); gap counter cleared -> POLL_GAP.
//  POLL_GAP: count POLL_GAP cycles -> POLL_RD.
//  POLL_RD: one cycle bus_read_en=1, bus_addr=0x00 -> POLL_WT.
//  POLL_WT: sample bus_rdata[9]. 1 -> start_compute<=0, idx=0 -> RES_RD.
//   0 -> poll_cnt++; poll_cnt==TIMEOUT_POLLS -> start_compute<=0, timeout_err<=1, busy<=0 -> IDLE;
//   else -> POLL_GAP.
//  RES_RD: bus_read_en=1, bus_addr=0x04+4*idx -> RES_WT.
//  RES_WT: score[idx]<=bus_rdata[7:0]; idx==NUM_CLASSES-1 -> FINISH else idx++ -> RES_RD.
//  FINISH: class_id = argmax, ties -> lowest index; result_valid=1 one cycle; busy<=0 -> IDLE.
//  Bus rules: bus_write_en and bus_read_en never both high; at most one strobe per cycle;
//   bus_addr/bus_wdata hold last value when no strobe.
//  job_start while busy: ignored, no effect. pix_valid low in LOAD: stall indefinitely.
//  Reset mid-job: immediate return to IDLE, start_compute drops asynchronously, partial word
//   discarded; scores cleared.
//  Counters: byte_cnt 2b, word_idx clog2(NUM_PIXELS/4), poll_cnt 16b saturating at TIMEOUT_POLLS.
// STRUCTURE
//  Shared package snn_host_pkg: register offsets (REG_STATUS=0x00, REG_RESULT0=0x04,
//   REG_STRIDE=4), STATUS_DONE_BIT=9, PIX_BASE default, FSM state enum.
//  One sub-module: snn_argmax (NUM_CLASSES x 8b -> index, lowest-index tie-break), combinational.
// TESTING
//  Reset then one image 0..255 repeating, pix_valid always 1 -> 768 writes, first
//   addr 0x100 data 0x03020100, last addr 0xCFC; start_compute rises 1 cycle after last write.
//  Slave model asserts done after 40 polls, results {3,9,1,9,0,0,0,0,0,2} -> 10 reads 0x04..0x28,
//   result_valid pulse, class_id=1 (tie 1/3 -> lowest), start_compute low.
//  Slave never done, TIMEOUT_POLLS=4 -> exactly 4 status reads, timeout_err=1, busy=0, no result_valid.
//  pix_valid toggled randomly 30% duty -> identical write sequence/data to test 1, no lost bytes.
//  job_start re-pulsed during POLL -> ignored; rst pulsed mid-LOAD -> all outputs 0 same cycle,
//   new job completes normally with word_idx restarting at 0x100.

Source files
------------

// File: rtl/snn_host_pkg.sv
// Shared constants for the SNN host sequencer: slave register map, status bit, FSM encoding.
package snn_host_pkg;

  localparam logic [31:0] REG_STATUS       = 32'h0000_0000;
  localparam logic [31:0] REG_RESULT0      = 32'h0000_0004;
  localparam logic [31:0] REG_STRIDE       = 32'h0000_0004;
  localparam int          STATUS_DONE_BIT  = 9;
  localparam logic [31:0] PIX_BASE_DEFAULT = 32'h0000_0100;

  localparam int STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_LOAD     = 4'd1;
  localparam state_t S_START    = 4'd2;
  localparam state_t S_POLL_GAP = 4'd3;
  localparam state_t S_POLL_RD  = 4'd4;
  localparam state_t S_POLL_WT  = 4'd5;
  localparam state_t S_RES_RD   = 4'd6;
  localparam state_t S_RES_WT   = 4'd7;
  localparam state_t S_FINISH   = 4'd8;

endpackage

// File: rtl/snn_argmax.sv
// Combinational argmax over NUM_CLASSES unsigned 8-bit scores; ties resolve to the lowest index.
module snn_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic [NUM_CLASSES*8-1:0] scores_i,
  output logic [IDX_W-1:0]         idx_o
);

  logic [7:0] best_val;

  // Strict '>' keeps the earliest index on equal scores.
  always_comb begin
    best_val = scores_i[7:0];
    idx_o    = '0;
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (scores_i[i*8 +: 8] > best_val) begin
        best_val = scores_i[i*8 +: 8];
        idx_o    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/snn_host_sequencer.sv
// Bus-master job sequencer: streams an image into the accelerator pixel window, starts compute,
// polls for done, reads back per-class scores and reports the argmax class.
module snn_host_sequencer
  import snn_host_pkg::*;
#(
  parameter int          NUM_PIXELS    = 3072,
  parameter int          NUM_CLASSES   = 10,
  parameter logic [31:0] PIX_BASE      = PIX_BASE_DEFAULT,
  parameter int          POLL_GAP      = 16,
  parameter int          TIMEOUT_POLLS = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_start,
  input  logic [7:0]               pix_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [31:0]              bus_addr,
  output logic [31:0]              bus_wdata,
  output logic                     bus_write_en,
  output logic                     bus_read_en,
  input  logic [31:0]              bus_rdata,
  output logic                     start_compute,
  output logic                     busy,
  output logic                     result_valid,
  output logic [NUM_CLASSES*8-1:0] scores,
  output logic [3:0]               class_id,
  output logic                     timeout_err,
  output logic [STATE_W-1:0]       dbg_state
);

  localparam int WORDS  = NUM_PIXELS / 4;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int IDX_W  = 4;

  state_t                   state_q, state_d;
  logic [1:0]               byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]        word_idx_q, word_idx_d;
  logic [23:0]              pack_q, pack_d;
  logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
  logic [15:0]              poll_cnt_q, poll_cnt_d, poll_inc;
  logic [IDX_W-1:0]         idx_q, idx_d, idx_nxt;
  logic [31:0]              addr_q, addr_d, wdata_q, wdata_d;
  logic                     wr_q, wr_d, rd_q, rd_d;
  logic                     start_q, start_d, busy_q, busy_d;
  logic                     rv_q, rv_d, tmo_q, tmo_d;
  logic [3:0]               class_q, class_d;
  logic [NUM_CLASSES*8-1:0] scores_q, scores_d;
  logic [IDX_W-1:0]         argmax_idx;
  logic                     pix_fire;
  logic                     unused_rdata;

  // Pixel handshake: a byte transfers on any cycle where pix_valid && pix_ready;
  // pix_ready is withheld outside LOAD and during the write-strobe cycle.
  assign pix_ready    = (state_q == S_LOAD) && !wr_q;
  assign pix_fire     = pix_valid && pix_ready;
  assign poll_inc     = (poll_cnt_q == 16'(TIMEOUT_POLLS)) ? poll_cnt_q : poll_cnt_q + 16'd1;
  assign idx_nxt      = idx_q + 1'b1;
  assign unused_rdata = ^{bus_rdata[31:10], bus_rdata[8]};

  snn_argmax #(.NUM_CLASSES(NUM_CLASSES), .IDX_W(IDX_W)) u_argmax (
    .scores_i (scores_q),
    .idx_o    (argmax_idx)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    pack_d     = pack_q;
    gap_cnt_d  = gap_cnt_q;
    poll_cnt_d = poll_cnt_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    start_d    = start_q;
    busy_d     = busy_q;
    rv_d       = 1'b0;
    tmo_d      = tmo_q;
    class_d    = class_q;
    scores_d   = scores_q;
    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          state_d    = S_LOAD;
          busy_d     = 1'b1;
          tmo_d      = 1'b0;
          byte_cnt_d = '0;
          word_idx_d = '0;
          poll_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (pix_fire) begin
          if (byte_cnt_q == 2'd3) begin
            wr_d       = 1'b1;
            addr_d     = PIX_BASE + 32'({word_idx_q, 2'b00});
            wdata_d    = {pix_data, pack_q};
            byte_cnt_d = '0;
            word_idx_d = word_idx_q + 1'b1;
            // The last write strobe coincides with START so compute begins right after it.
            if (word_idx_q == WORD_W'(WORDS - 1)) state_d = S_START;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    pack_d[7:0]   = pix_data;
              2'd1:    pack_d[15:8]  = pix_data;
              default: pack_d[23:16] = pix_data;
            endcase
          end
        end
      end
      S_START: begin
        start_d   = 1'b1;
        gap_cnt_d = '0;
        state_d   = S_POLL_GAP;
      end
      S_POLL_GAP: begin
        if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) begin
          state_d = S_POLL_RD;
          rd_d    = 1'b1;
          addr_d  = REG_STATUS;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_POLL_RD: state_d = S_POLL_WT;
      S_POLL_WT: begin
        if (bus_rdata[STATUS_DONE_BIT]) begin
          start_d = 1'b0;
          idx_d   = '0;
          state_d = S_RES_RD;
          rd_d    = 1'b1;
          addr_d  = REG_RESULT0;
        end else begin
          poll_cnt_d = poll_inc;
          if (poll_inc == 16'(TIMEOUT_POLLS)) begin
            start_d = 1'b0;
            tmo_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = '0;
            state_d   = S_POLL_GAP;
          end
        end
      end
      S_RES_RD: state_d = S_RES_WT;
      S_RES_WT: begin
        for (int i = 0; i < NUM_CLASSES; i++) begin
          if (idx_q == IDX_W'(i)) scores_d[i*8 +: 8] = bus_rdata[7:0];
        end
        if (idx_q == IDX_W'(NUM_CLASSES - 1)) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_nxt;
          rd_d    = 1'b1;
          addr_d  = REG_RESULT0 + REG_STRIDE * 32'(idx_nxt);
          state_d = S_RES_RD;
        end
      end
      S_FINISH: begin
        class_d = argmax_idx;
        rv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      pack_q     <= '0;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      tmo_q      <= 1'b0;
      class_q    <= '0;
      scores_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      pack_q     <= pack_d;
      gap_cnt_q  <= gap_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      tmo_q      <= tmo_d;
      class_q    <= class_d;
      scores_q   <= scores_d;
    end
  end

  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_write_en  = wr_q;
  assign bus_read_en   = rd_q;
  assign start_compute = start_q;
  assign busy          = busy_q;
  assign result_valid  = rv_q;
  assign scores        = scores_q;
  assign class_id      = class_q;
  assign timeout_err   = tmo_q;
  assign dbg_state     = state_q;

endmodule
